// File: rtl/lsu_translation_arbiter_if.sv
// Bundles the load/store request side and the MMU translation port of
// lsu_translation_arbiter; the arbiter uses slave, its environment uses master.
interface lsu_translation_arbiter_if #(
  parameter int unsigned VLEN  = 39,
  parameter int unsigned PLEN  = 56,
  parameter int unsigned CNT_W = 16
) ();

  logic             flush_i;
  logic             ld_req_i;
  logic [VLEN-1:0]  ld_vaddr_i;
  logic             ld_hit_o;
  logic             st_req_i;
  logic [VLEN-1:0]  st_vaddr_i;
  logic             st_hit_o;
  logic [PLEN-1:0]  paddr_o;
  logic             ex_valid_o;
  logic             mmu_req_o;
  logic [VLEN-1:0]  mmu_vaddr_o;
  logic             mmu_hit_i;
  logic             mmu_ex_valid_i;
  logic [PLEN-1:0]  mmu_paddr_i;
  logic             all_tlbs_checked_i;
  logic [CNT_W-1:0] walk_cycles_o;
  logic [CNT_W-1:0] contention_cnt_o;

  modport slave (
    input  flush_i, ld_req_i, ld_vaddr_i, st_req_i, st_vaddr_i,
           mmu_hit_i, mmu_ex_valid_i, mmu_paddr_i, all_tlbs_checked_i,
    output ld_hit_o, st_hit_o, paddr_o, ex_valid_o, mmu_req_o, mmu_vaddr_o,
           walk_cycles_o, contention_cnt_o
  );

  modport master (
    output flush_i, ld_req_i, ld_vaddr_i, st_req_i, st_vaddr_i,
           mmu_hit_i, mmu_ex_valid_i, mmu_paddr_i, all_tlbs_checked_i,
    input  ld_hit_o, st_hit_o, paddr_o, ex_valid_o, mmu_req_o, mmu_vaddr_o,
           walk_cycles_o, contention_cnt_o
  );

endinterface

// File: rtl/lsu_translation_arbiter.sv
// Round-robin sharing of the data-side MMU port between load and store units;
// a missing request holds the grant until its lookup or page-table walk finishes.
module lsu_translation_arbiter #(
  parameter int unsigned VLEN  = 39,
  parameter int unsigned PLEN  = 56,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  lsu_translation_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_LD = 2'd1,
    LOCK_ST = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
  logic [CNT_W-1:0] walk_cycles_q, walk_cycles_d;
  logic [CNT_W-1:0] cont_cnt_q, cont_cnt_d;
  logic [CNT_W-1:0] walk_inc;

  logic             done;
  logic             both;
  logic             ld_wins;
  logic             st_wins;
  logic             ld_hit;
  logic             st_hit;
  logic             mmu_req;
  logic [VLEN-1:0]  mmu_vaddr;
  logic [PLEN-1:0]  paddr;
  logic             unused_walk_start;

  assign done     = bus.mmu_hit_i | bus.mmu_ex_valid_i;
  assign both     = bus.ld_req_i & bus.st_req_i;
  assign walk_inc = (walk_cnt_q == CNT_MAX) ? CNT_MAX : walk_cnt_q + CNT_W'(1);

  // Walk start is implied by staying locked; the walk counter spans both phases.
  assign unused_walk_start = bus.all_tlbs_checked_i;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    walk_cnt_d    = walk_cnt_q;
    walk_cycles_d = walk_cycles_q;
    ld_hit        = 1'b0;
    st_hit        = 1'b0;
    mmu_req       = 1'b0;
    mmu_vaddr     = bus.ld_vaddr_i;
    ld_wins       = bus.ld_req_i & (~bus.st_req_i | ~rr_q);
    st_wins       = bus.st_req_i & ~ld_wins;

    unique case (state_q)
      IDLE: begin
        mmu_req   = bus.ld_req_i | bus.st_req_i;
        mmu_vaddr = st_wins ? bus.st_vaddr_i : bus.ld_vaddr_i;
        ld_hit    = ld_wins & done;
        st_hit    = st_wins & done;
        if (both) begin
          rr_d = ld_wins;
        end
        if (mmu_req && !done) begin
          state_d    = ld_wins ? LOCK_LD : LOCK_ST;
          walk_cnt_d = '0;
        end
      end
      LOCK_LD: begin
        mmu_req    = bus.ld_req_i;
        mmu_vaddr  = bus.ld_vaddr_i;
        walk_cnt_d = walk_inc;
        if (!bus.ld_req_i) begin
          state_d = IDLE;
        end else if (done) begin
          ld_hit        = 1'b1;
          state_d       = IDLE;
          rr_d          = 1'b1;
          walk_cycles_d = walk_inc;
        end
      end
      LOCK_ST: begin
        mmu_req    = bus.st_req_i;
        mmu_vaddr  = bus.st_vaddr_i;
        walk_cnt_d = walk_inc;
        if (!bus.st_req_i) begin
          state_d = IDLE;
        end else if (done) begin
          st_hit        = 1'b1;
          state_d       = IDLE;
          rr_d          = 1'b0;
          walk_cycles_d = walk_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.flush_i) begin
      state_d = IDLE;
    end

    // Whenever both ask, exactly one is forwarded or holds the lock.
    cont_cnt_d = (both && (cont_cnt_q != CNT_MAX)) ? cont_cnt_q + CNT_W'(1) : cont_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      walk_cnt_q    <= '0;
      walk_cycles_q <= '0;
      cont_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      walk_cnt_q    <= walk_cnt_d;
      walk_cycles_q <= walk_cycles_d;
      cont_cnt_q    <= cont_cnt_d;
    end
  end

  assign paddr                = bus.mmu_paddr_i;
  assign bus.paddr_o          = paddr;
  assign bus.ex_valid_o       = bus.mmu_ex_valid_i;
  assign bus.ld_hit_o         = ld_hit;
  assign bus.st_hit_o         = st_hit;
  assign bus.mmu_req_o        = mmu_req;
  assign bus.mmu_vaddr_o      = mmu_vaddr;
  assign bus.walk_cycles_o    = walk_cycles_q;
  assign bus.contention_cnt_o = cont_cnt_q;

endmodule
